toggle_event_link: RTL and testbench

//  Multi-channel, flow-controlled event bridge between two clock domains using toggle signalling.
//  One instance sits in each domain; tx_tgl/rx_ack_tgl of one instance connect to rx_tgl/tx_ack_tgl of the other.

---
 rtl/toggle_event_link_pkg.sv | 18 +
 rtl/toggle_event_link_sync.sv | 26 ++
 rtl/toggle_event_link.sv | 146 ++++++++++++++
 tb/tb_toggle_event_link.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_event_link_pkg.sv
// Shared types and defaults for the toggle event link: TX FSM state encoding,
// default synchronizer depth and pending-counter width, and a gap-counter sizing helper.
package toggle_event_link_pkg;

  typedef enum logic {
    TL_IDLE = 1'b0,
    TL_WAIT = 1'b1
  } tl_state_e;

  localparam int TL_DEF_DEPTH = 2;
  localparam int TL_DEF_CNT_W = 4;

  // Bits needed to hold MIN_GAP-1; never narrower than one bit.
  function automatic int tl_gap_width(input int min_gap);
    return (min_gap > 1) ? $clog2(min_gap) : 1;
  endfunction

endpackage

// File: rtl/toggle_event_link_sync.sv
// W-bit, DEPTH-stage synchronizer with asynchronous active-low reset.
// Its first stage is the only place an asynchronous toggle line is sampled.
module toggle_event_link_sync #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_sync
);

  logic [W-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_async;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_sync = r_stage[DEPTH-1];

endmodule

// File: rtl/toggle_event_link.sv
// Multi-channel toggle-signalled event bridge end. Local events are counted and
// launched as toggles; incoming toggles become valid/ready events, optionally acknowledged.
module toggle_event_link
  import toggle_event_link_pkg::*;
#(
  parameter int N_CH    = 1,
  parameter int DEPTH   = TL_DEF_DEPTH,
  parameter int CNT_W   = TL_DEF_CNT_W,
  parameter int ACK_EN  = 1,
  parameter int MIN_GAP = 4
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic [N_CH-1:0] ev_in,
  output logic [N_CH-1:0] tx_tgl,
  input  logic [N_CH-1:0] tx_ack_tgl,
  output logic [N_CH-1:0] tx_busy,
  output logic [N_CH-1:0] tx_ovf,
  input  logic [N_CH-1:0] ovf_clr,
  input  logic [N_CH-1:0] rx_tgl,
  output logic [N_CH-1:0] rx_valid,
  input  logic [N_CH-1:0] rx_ready,
  output logic [N_CH-1:0] rx_ack_tgl
);

  localparam int                GAP_W     = tl_gap_width(MIN_GAP);
  localparam logic [CNT_W-1:0]  PEND_MAX  = '1;
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(MIN_GAP - 1);
  localparam bit                SKIP_WAIT = (ACK_EN == 0) && (MIN_GAP == 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("toggle_event_link: DEPTH must be at least 2");
  end
  if (MIN_GAP < 1) begin : g_bad_gap
    $error("toggle_event_link: MIN_GAP must be at least 1");
  end

  // Reset asserts asynchronously but is released on a clk edge.
  logic [1:0] r_rst_pipe;
  logic       w_rstb;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_rst_pipe <= 2'b00;
    else       r_rst_pipe <= {r_rst_pipe[0], 1'b1};
  end

  assign w_rstb = r_rst_pipe[1];

  logic [N_CH-1:0] w_rx_sync;
  logic [N_CH-1:0] w_ack_sync;

  toggle_event_link_sync #(.W(N_CH), .DEPTH(DEPTH)) u_rx_sync (
    .clk     (clk),
    .rstb    (w_rstb),
    .i_async (rx_tgl),
    .o_sync  (w_rx_sync)
  );

  toggle_event_link_sync #(.W(N_CH), .DEPTH(DEPTH)) u_ack_sync (
    .clk     (clk),
    .rstb    (w_rstb),
    .i_async (tx_ack_tgl),
    .o_sync  (w_ack_sync)
  );

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    tl_state_e        r_state;
    logic [CNT_W-1:0] r_pend;
    logic [GAP_W-1:0] r_gap;
    logic             r_tgl;
    logic             r_ovf;
    logic             w_launch;
    logic             w_drop;
    logic             w_wait_done;

    assign w_launch = (r_state == TL_IDLE) && ((r_pend != '0) || ev_in[ch]);
    assign w_drop   = ev_in[ch] && !w_launch && (r_pend == PEND_MAX);

    // Acknowledged mode waits for the returned toggle; otherwise a fixed launch gap.
    if (ACK_EN != 0) begin : g_ack_wait
      assign w_wait_done = (w_ack_sync[ch] == r_tgl);
    end else begin : g_gap_wait
      assign w_wait_done = (r_gap <= GAP_W'(1));
    end

    always_ff @(posedge clk or negedge w_rstb) begin
      if (!w_rstb) begin
        r_state <= TL_IDLE;
        r_pend  <= '0;
        r_gap   <= '0;
        r_tgl   <= 1'b0;
        r_ovf   <= 1'b0;
      end else begin
        if (w_launch) begin
          r_tgl   <= ~r_tgl;
          r_gap   <= GAP_LOAD;
          r_state <= SKIP_WAIT ? TL_IDLE : TL_WAIT;
        end else if (r_state == TL_WAIT) begin
          if (r_gap != '0) r_gap <= r_gap - GAP_W'(1);
          if (w_wait_done) r_state <= TL_IDLE;
        end

        if (w_launch && !ev_in[ch])
          r_pend <= r_pend - CNT_W'(1);
        else if (!w_launch && ev_in[ch] && !w_drop)
          r_pend <= r_pend + CNT_W'(1);

        if (w_drop)           r_ovf <= 1'b1;
        else if (ovf_clr[ch]) r_ovf <= 1'b0;
      end
    end

    assign tx_tgl[ch]  = r_tgl;
    assign tx_busy[ch] = (r_pend != '0) || (r_state == TL_WAIT);
    assign tx_ovf[ch]  = r_ovf;

    logic r_hist;
    logic r_valid;
    logic r_ack;
    logic w_edge;

    assign w_edge = w_rx_sync[ch] ^ r_hist;

    // The far TX cannot toggle again until acknowledged, so edge and hold never collide.
    always_ff @(posedge clk or negedge w_rstb) begin
      if (!w_rstb) begin
        r_hist  <= 1'b0;
        r_valid <= 1'b0;
        r_ack   <= 1'b0;
      end else begin
        r_hist <= w_rx_sync[ch];
        if (ACK_EN != 0) begin
          r_valid <= (r_valid && !rx_ready[ch]) || w_edge;
          if (r_valid && rx_ready[ch]) r_ack <= ~r_ack;
        end else begin
          r_valid <= w_edge;
          r_ack   <= 1'b0;
        end
      end
    end

    assign rx_valid[ch]   = r_valid;
    assign rx_ack_tgl[ch] = r_ack;
  end

endmodule

// File: tb/tb_toggle_event_link.sv
// Bench for toggle_event_link: an acknowledged 4-channel pair across 10ns/37ns clocks
// and a fire-and-forget single-channel pair on one clock, with directed scenarios.
module tb_toggle_event_link;

  localparam int NCH = 4;

  logic clkA = 1'b0;
  logic clkB = 1'b0;
  logic rstb = 1'b1;

  logic [NCH-1:0] a_ev = '0, a_ovf_clr = '0, a_rx_ready = '1;
  logic [NCH-1:0] a_tx_tgl, a_tx_busy, a_tx_ovf, a_rx_valid, a_rx_ack;
  logic [NCH-1:0] b_ev = '0, b_ovf_clr = '0, b_rx_ready = '1;
  logic [NCH-1:0] b_tx_tgl, b_tx_busy, b_tx_ovf, b_rx_valid, b_rx_ack;

  logic [0:0] f0_ev = '0, f0_ovf_clr = '0, f0_rx_ready = '1;
  logic [0:0] f0_tx_tgl, f0_tx_busy, f0_tx_ovf, f0_rx_valid, f0_rx_ack;
  logic [0:0] f1_ev = '0, f1_ovf_clr = '0, f1_rx_ready = '0;
  logic [0:0] f1_tx_tgl, f1_tx_busy, f1_tx_ovf, f1_rx_valid, f1_rx_ack;

  int n_cmp = 0;
  int n_mis = 0;
  int hs_cnt [NCH] = '{default: 0};
  int base   [NCH];

  initial forever #5 clkA = ~clkA;
  initial forever begin
    #18 clkB = 1'b1;
    #19 clkB = 1'b0;
  end

  toggle_event_link #(.N_CH(NCH), .DEPTH(2), .CNT_W(2), .ACK_EN(1), .MIN_GAP(4)) u_a (
    .clk(clkA), .rstb(rstb), .ev_in(a_ev), .tx_tgl(a_tx_tgl), .tx_ack_tgl(b_rx_ack),
    .tx_busy(a_tx_busy), .tx_ovf(a_tx_ovf), .ovf_clr(a_ovf_clr), .rx_tgl(b_tx_tgl),
    .rx_valid(a_rx_valid), .rx_ready(a_rx_ready), .rx_ack_tgl(a_rx_ack)
  );

  toggle_event_link #(.N_CH(NCH), .DEPTH(2), .CNT_W(2), .ACK_EN(1), .MIN_GAP(4)) u_b (
    .clk(clkB), .rstb(rstb), .ev_in(b_ev), .tx_tgl(b_tx_tgl), .tx_ack_tgl(a_rx_ack),
    .tx_busy(b_tx_busy), .tx_ovf(b_tx_ovf), .ovf_clr(b_ovf_clr), .rx_tgl(a_tx_tgl),
    .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .rx_ack_tgl(b_rx_ack)
  );

  toggle_event_link #(.N_CH(1), .DEPTH(2), .CNT_W(4), .ACK_EN(0), .MIN_GAP(4)) u_f0 (
    .clk(clkA), .rstb(rstb), .ev_in(f0_ev), .tx_tgl(f0_tx_tgl), .tx_ack_tgl(f1_rx_ack),
    .tx_busy(f0_tx_busy), .tx_ovf(f0_tx_ovf), .ovf_clr(f0_ovf_clr), .rx_tgl(f1_tx_tgl),
    .rx_valid(f0_rx_valid), .rx_ready(f0_rx_ready), .rx_ack_tgl(f0_rx_ack)
  );

  toggle_event_link #(.N_CH(1), .DEPTH(2), .CNT_W(4), .ACK_EN(0), .MIN_GAP(4)) u_f1 (
    .clk(clkA), .rstb(rstb), .ev_in(f1_ev), .tx_tgl(f1_tx_tgl), .tx_ack_tgl(f0_rx_ack),
    .tx_busy(f1_tx_busy), .tx_ovf(f1_tx_ovf), .ovf_clr(f1_ovf_clr), .rx_tgl(f0_tx_tgl),
    .rx_valid(f1_rx_valid), .rx_ready(f1_rx_ready), .rx_ack_tgl(f1_rx_ack)
  );

  // Far-side handshakes counted mid-cycle, where valid and ready are both stable.
  always @(negedge clkB) begin
    for (int c = 0; c < NCH; c++)
      if (b_rx_valid[c] && b_rx_ready[c]) hs_cnt[c]++;
  end

  task automatic a_cycles(input int n);
    repeat (n) @(posedge clkA);
    #1;
  endtask

  task automatic test_reset();
    #1 rstb = 1'b0;
    #2;
    n_cmp++;
    if ({a_tx_tgl, a_tx_busy, a_tx_ovf, a_rx_valid, a_rx_ack} !== 20'h0) begin
      n_mis++;
      $display("[TB] FAIL reset_initial_a: got %h expected 0",
               {a_tx_tgl, a_tx_busy, a_tx_ovf, a_rx_valid, a_rx_ack});
    end
    #20 rstb = 1'b1;
    a_cycles(20);
    a_ev = 4'hF;
    b_ev = 4'h3;
    a_cycles(1);
    a_ev = '0;
    b_ev = '0;
    a_cycles(3);
    #2 rstb = 1'b0;
    #1;
    n_cmp++;
    if ({a_tx_tgl, a_tx_busy, a_tx_ovf, a_rx_valid, a_rx_ack} !== 20'h0) begin
      n_mis++;
      $display("[TB] FAIL reset_midtraffic_a: got %h expected 0",
               {a_tx_tgl, a_tx_busy, a_tx_ovf, a_rx_valid, a_rx_ack});
    end
    n_cmp++;
    if ({b_tx_tgl, b_tx_busy, b_tx_ovf, b_rx_valid, b_rx_ack} !== 20'h0) begin
      n_mis++;
      $display("[TB] FAIL reset_midtraffic_b: got %h expected 0",
               {b_tx_tgl, b_tx_busy, b_tx_ovf, b_rx_valid, b_rx_ack});
    end
    a_cycles(3);
    rstb = 1'b1;
    base = hs_cnt;
    a_cycles(60);
    n_cmp++;
    if ({a_rx_valid, b_rx_valid} !== 8'h0) begin
      n_mis++;
      $display("[TB] FAIL reset_spurious_valid: got %h expected 0", {a_rx_valid, b_rx_valid});
    end
    n_cmp++;
    if ((hs_cnt[0] + hs_cnt[1] + hs_cnt[2] + hs_cnt[3]) - (base[0] + base[1] + base[2] + base[3]) != 0) begin
      n_mis++;
      $display("[TB] FAIL reset_spurious_handshake: got %0d expected 0",
               (hs_cnt[0] + hs_cnt[1] + hs_cnt[2] + hs_cnt[3]) - (base[0] + base[1] + base[2] + base[3]));
    end
    n_cmp++;
    if ({a_tx_busy, b_tx_busy} !== 8'h0) begin
      n_mis++;
      $display("[TB] FAIL reset_busy_after_release: got %h expected 0", {a_tx_busy, b_tx_busy});
    end
  endtask

  task automatic test_stream();
    int offs [NCH];
    bit done;
    base = hs_cnt;
    for (int it = 0; it < 100; it++) begin
      for (int c = 0; c < NCH; c++) offs[c] = $urandom_range(0, 29);
      for (int t = 0; t < 30; t++) begin
        for (int c = 0; c < NCH; c++) a_ev[c] = (t == offs[c]);
        a_cycles(1);
      end
    end
    a_ev = '0;
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      a_cycles(1);
      done = (a_tx_busy == '0);
      for (int c = 0; c < NCH; c++) if (hs_cnt[c] - base[c] < 100) done = 1'b0;
    end
    a_cycles(50);
    for (int c = 0; c < NCH; c++) begin
      n_cmp++;
      if (hs_cnt[c] - base[c] != 100) begin
        n_mis++;
        $display("[TB] FAIL stream_count_ch%0d: got %0d expected 100", c, hs_cnt[c] - base[c]);
      end
    end
    n_cmp++;
    if (a_tx_ovf !== 4'h0) begin
      n_mis++;
      $display("[TB] FAIL stream_no_overflow: got %h expected 0", a_tx_ovf);
    end
  endtask

  task automatic test_burst();
    for (int pass = 0; pass < 2; pass++) begin
      base = hs_cnt;
      for (int t = 0; t < 5; t++) begin
        a_ev = 4'b0001;
        a_ovf_clr = (pass == 1 && t == 4) ? 4'b0001 : 4'b0000;
        a_cycles(1);
      end
      a_ev = '0;
      a_ovf_clr = '0;
      n_cmp++;
      if ({a_tx_ovf[0], a_tx_busy[0]} !== 2'b11) begin
        n_mis++;
        $display("[TB] FAIL burst_ovf_busy_pass%0d: got %b expected 11", pass, {a_tx_ovf[0], a_tx_busy[0]});
      end
      for (int k = 0; k < 600 && (a_tx_busy[0] || hs_cnt[0] - base[0] < 4); k++) a_cycles(1);
      a_cycles(100);
      n_cmp++;
      if (hs_cnt[0] - base[0] != 4) begin
        n_mis++;
        $display("[TB] FAIL burst_delivered_pass%0d: got %0d expected 4", pass, hs_cnt[0] - base[0]);
      end
      n_cmp++;
      if (a_tx_ovf !== 4'b0001) begin
        n_mis++;
        $display("[TB] FAIL burst_ovf_sticky_pass%0d: got %b expected 0001", pass, a_tx_ovf);
      end
      a_ovf_clr = 4'b0001;
      a_cycles(1);
      a_ovf_clr = '0;
      n_cmp++;
      if (a_tx_ovf !== 4'b0000) begin
        n_mis++;
        $display("[TB] FAIL burst_ovf_clear_pass%0d: got %b expected 0000", pass, a_tx_ovf);
      end
    end
  endtask

  task automatic test_backpressure();
    logic ack0, tgl0;
    @(posedge clkB);
    #2 b_rx_ready[1] = 1'b0;
    a_cycles(1);
    base = hs_cnt;
    ack0 = b_rx_ack[1];
    tgl0 = a_tx_tgl[1];
    a_ev = 4'b0010;
    a_cycles(1);
    a_ev = '0;
    a_cycles(2);
    a_ev = 4'b0010;
    a_cycles(1);
    a_ev = '0;
    repeat (50) @(posedge clkB);
    a_cycles(1);
    n_cmp++;
    if ({b_rx_valid[1], b_rx_ack[1], a_tx_busy[1], a_tx_tgl[1]} !== {1'b1, ack0, 1'b1, ~tgl0}) begin
      n_mis++;
      $display("[TB] FAIL backpressure_hold: got %b expected %b",
               {b_rx_valid[1], b_rx_ack[1], a_tx_busy[1], a_tx_tgl[1]}, {1'b1, ack0, 1'b1, ~tgl0});
    end
    n_cmp++;
    if (hs_cnt[1] - base[1] != 0) begin
      n_mis++;
      $display("[TB] FAIL backpressure_no_handshake: got %0d expected 0", hs_cnt[1] - base[1]);
    end
    @(posedge clkB);
    #2 b_rx_ready[1] = 1'b1;
    for (int k = 0; k < 600 && (a_tx_busy[1] || hs_cnt[1] - base[1] < 2); k++) a_cycles(1);
    a_cycles(60);
    n_cmp++;
    if (hs_cnt[1] - base[1] != 2) begin
      n_mis++;
      $display("[TB] FAIL backpressure_release_count: got %0d expected 2", hs_cnt[1] - base[1]);
    end
    n_cmp++;
    if ({a_tx_tgl[1], b_rx_ack[1], a_tx_busy[1]} !== {tgl0, ack0, 1'b0}) begin
      n_mis++;
      $display("[TB] FAIL backpressure_release_state: got %b expected %b",
               {a_tx_tgl[1], b_rx_ack[1], a_tx_busy[1]}, {tgl0, ack0, 1'b0});
    end
  endtask

  task automatic test_simultaneous();
    bit done;
    base = hs_cnt;
    a_ev = 4'hF;
    a_cycles(1);
    a_cycles(1);
    a_ev = '0;
    n_cmp++;
    if (a_tx_busy !== 4'hF) begin
      n_mis++;
      $display("[TB] FAIL simul_busy: got %h expected f", a_tx_busy);
    end
    done = 1'b0;
    for (int k = 0; k < 600 && !done; k++) begin
      a_cycles(1);
      done = (a_tx_busy == '0);
      for (int c = 0; c < NCH; c++) if (hs_cnt[c] - base[c] < 2) done = 1'b0;
    end
    a_cycles(60);
    for (int c = 0; c < NCH; c++) begin
      n_cmp++;
      if (hs_cnt[c] - base[c] != 2) begin
        n_mis++;
        $display("[TB] FAIL simul_count_ch%0d: got %0d expected 2", c, hs_cnt[c] - base[c]);
      end
    end
  endtask

  task automatic test_fire_forget();
    int launch_t [$];
    int first_valid, pulses, wide;
    logic prev_tgl, prev_valid, ack_seen;
    prev_tgl = f0_tx_tgl[0];
    prev_valid = 1'b0;
    ack_seen = 1'b0;
    first_valid = -1;
    pulses = 0;
    wide = 0;
    for (int i = 0; i < 70; i++) begin
      f0_ev[0] = (i < 12);
      a_cycles(1);
      if (f0_tx_tgl[0] !== prev_tgl) launch_t.push_back(i);
      prev_tgl = f0_tx_tgl[0];
      if (f1_rx_valid[0]) begin
        if (prev_valid) wide++;
        else pulses++;
        if (first_valid < 0) first_valid = i;
      end
      prev_valid = f1_rx_valid[0];
      if (f1_rx_ack[0] !== 1'b0) ack_seen = 1'b1;
    end
    f0_ev[0] = 1'b0;
    n_cmp++;
    if (launch_t.size() != 12) begin
      n_mis++;
      $display("[TB] FAIL ff_launch_count: got %0d expected 12", launch_t.size());
    end
    n_cmp++;
    if (launch_t.size() == 0 || launch_t[0] != 0) begin
      n_mis++;
      $display("[TB] FAIL ff_first_launch: got %0d expected 0", (launch_t.size() == 0) ? -1 : launch_t[0]);
    end
    for (int j = 1; j < launch_t.size(); j++) begin
      n_cmp++;
      if (launch_t[j] - launch_t[j-1] != 4) begin
        n_mis++;
        $display("[TB] FAIL ff_gap_%0d: got %0d expected 4", j, launch_t[j] - launch_t[j-1]);
      end
    end
    n_cmp++;
    if (pulses != 12 || wide != 0) begin
      n_mis++;
      $display("[TB] FAIL ff_rx_pulses: got %0d pulses %0d wide expected 12 pulses 0 wide", pulses, wide);
    end
    n_cmp++;
    if (first_valid != 3) begin
      n_mis++;
      $display("[TB] FAIL ff_rx_latency: got %0d expected 3", first_valid);
    end
    n_cmp++;
    if ({ack_seen, f0_tx_ovf[0], f0_tx_busy[0]} !== 3'b000) begin
      n_mis++;
      $display("[TB] FAIL ff_idle_state: got %b expected 000", {ack_seen, f0_tx_ovf[0], f0_tx_busy[0]});
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_burst();
    test_backpressure();
    test_simultaneous();
    test_fire_forget();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
